// File: rtl/puf_resp_collector_if.sv
// ----------------------------------------------------------------------------
// puf_resp_collector_if
//   Valid/ready handshake that carries one collected PUF response word from
//   the collector (master) to its consumer (slave).
//
//   resp_word   N_BITS  collected response, bit i = response to i-th challenge
//   resp_valid  1       resp_word is available and held stable
//   resp_ready  1       consumer accepts resp_word this cycle
// ----------------------------------------------------------------------------
interface puf_resp_collector_if #(
    parameter int N_BITS = 8
);
    logic [N_BITS-1:0] resp_word;
    logic              resp_valid;
    logic              resp_ready;

    modport master (
        output resp_word,
        output resp_valid,
        input  resp_ready
    );

    modport slave (
        input  resp_word,
        input  resp_valid,
        output resp_ready
    );
endinterface

// File: rtl/puf_resp_collector.sv
// ----------------------------------------------------------------------------
// puf_resp_collector
//   Challenge-side sequencer for a single-bit ring-oscillator PUF. A start
//   pulse captures an 8-bit seed; an LFSR (x^8+x^6+x^5+x^4+1) expands it into
//   N_BITS challenges. Each challenge gets one clear cycle followed by an
//   enabled run that lasts until the PUF reports finish. The response bits
//   are gathered into a word and offered on a valid/ready handshake. A
//   per-bit watchdog aborts into a sticky error state if the PUF never
//   finishes.
//
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   start_i       in   request pulse, honoured only in IDLE or ERR
//   seed_i[7:0]   in   LFSR seed, captured with start_i (0 is replaced by A5)
//   busy_o        out  high while a request is in progress (CLEAR/RUN/DONE)
//   error_o       out  watchdog expired; sticky until the next accepted start
//   puf_chall_o   out  challenge to the PUF
//   puf_en_o      out  ring-oscillator enable
//   puf_rst_o     out  synchronous clear of the PUF counters/arbiter
//   puf_resp_i    in   PUF response bit, valid with puf_finish_i
//   puf_finish_i  in   PUF race complete
//   resp_if       master side of the response word handshake
// ----------------------------------------------------------------------------
module puf_resp_collector #(
    parameter int N_BITS  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [7:0]                  seed_i,
    output logic                        busy_o,
    output logic                        error_o,
    output logic [7:0]                  puf_chall_o,
    output logic                        puf_en_o,
    output logic                        puf_rst_o,
    input  logic                        puf_resp_i,
    input  logic                        puf_finish_i,
    puf_resp_collector_if.master        resp_if
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [N_BITS-1:0] word_q, word_d;
    logic [7:0]        chall_q, chall_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              en_q, en_d;
    logic              prst_q, prst_d;
    logic              lfsr_fb;

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        word_d    = word_q;
        chall_d   = chall_q;
        error_d   = error_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start_i) begin
                    // An all-zero LFSR would lock up, so a zero seed is substituted.
                    lfsr_d    = (seed_i == 8'h00) ? 8'hA5 : seed_i;
                    bit_cnt_d = '0;
                    error_d   = 1'b0;
                    word_d    = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                chall_d = lfsr_q;
                timer_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Finish takes priority over a watchdog expiry in the same cycle.
                if (puf_finish_i) begin
                    word_d[bit_cnt_q] = puf_resp_i;
                    lfsr_d            = {lfsr_q[6:0], lfsr_fb};
                    if (bit_cnt_q == CW'(N_BITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        state_d   = S_CLEAR;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                if (valid_q && resp_if.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they land in registers
        // aligned with the state they describe.
        busy_d  = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DONE);
        valid_d = (state_d == S_DONE);
        en_d    = (state_d == S_RUN);
        prst_d  = (state_d != S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            word_q    <= '0;
            chall_q   <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            en_q      <= 1'b0;
            prst_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            word_q    <= word_d;
            chall_q   <= chall_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            en_q      <= en_d;
            prst_q    <= prst_d;
        end
    end

    assign busy_o             = busy_q;
    assign error_o            = error_q;
    assign puf_chall_o        = chall_q;
    assign puf_en_o           = en_q;
    assign puf_rst_o          = prst_q;
    assign resp_if.resp_word  = word_q;
    assign resp_if.resp_valid = valid_q;

endmodule
